pipe_stage_reg: RTL

//   Generic elastic pipeline register; replaces the fixed IF_ID/ID_EX/EX_MEM/MEM_WB stage registers.

---
 rtl/pipe_stage_reg.sv | 103 ++++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register between two core stages: valid/ready handshake,
// hazard stall, branch flush, bubble injection, optional 2-entry skid buffer.
module pipe_stage_reg #(
    parameter int                 DATA_W      = 64,
    parameter int                 CTRL_W      = 8,
    parameter int                 SKID        = 1,
    parameter logic [CTRL_W-1:0]  BUBBLE_CTRL = '0,
    parameter int                 CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              stall,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt,
    input  logic              cnt_clr
);

    logic              rdy;
    logic              main_v, skid_v;
    logic [DATA_W-1:0] main_data, skid_data;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
    logic              accept, emit;

    // rdy keeps in_ready low until the first edge after reset release
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rdy <= 1'b0;
        else      rdy <= 1'b1;
    end

    generate
        if (SKID != 0) begin : g_skid
            assign in_ready = rdy & ~skid_v & ~stall;
        end else begin : g_noskid
            assign in_ready = rdy & ~stall & (~main_v | out_ready);
        end
    endgenerate

    assign out_valid = main_v & ~stall;
    assign out_data  = main_data;
    assign out_ctrl  = out_valid ? main_ctrl : BUBBLE_CTRL;
    assign occupancy = {1'b0, main_v} + {1'b0, skid_v};
    assign accept    = in_valid & in_ready;
    assign emit      = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_v    <= 1'b0;
            skid_v    <= 1'b0;
            main_data <= '0;
            main_ctrl <= '0;
            skid_data <= '0;
            skid_ctrl <= '0;
        end else if (rdy) begin
            if (flush) begin
                main_v <= 1'b0;
                skid_v <= 1'b0;
            end else if (!stall) begin
                if (emit) begin
                    if (skid_v) begin
                        // in_ready is low while skid_v, so no accept can collide here
                        main_data <= skid_data;
                        main_ctrl <= skid_ctrl;
                        skid_v    <= 1'b0;
                    end else if (accept) begin
                        main_data <= in_data;
                        main_ctrl <= in_ctrl;
                    end else begin
                        main_v <= 1'b0;
                    end
                end else if (accept) begin
                    if (main_v) begin
                        if (SKID != 0) begin
                            skid_data <= in_data;
                            skid_ctrl <= in_ctrl;
                            skid_v    <= 1'b1;
                        end
                    end else begin
                        main_data <= in_data;
                        main_ctrl <= in_ctrl;
                        main_v    <= 1'b1;
                    end
                end
            end
        end
    end

    // Saturating stall counter; clear wins over a same-cycle increment
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                         stall_cnt <= '0;
        else if (cnt_clr)                 stall_cnt <= '0;
        else if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
    end

endmodule
